// File: rtl/lift_scheduler.sv
// Purpose: SCAN-policy lift controller; latches floor calls, times floor moves and door-open intervals.
// Latency: call sampled at edge t appears in pending after t; the idle decision acts on it at edge t+1.
// Backpressure: none; calls are level/pulse inputs latched every cycle; outputs are registered status.
module lift_scheduler #(
    parameter int N_FLOORS   = 4,
    parameter int FLOOR_W    = 2,
    parameter int TRAVEL_CYC = 50000000,
    parameter int DOOR_CYC   = 100000000
) (
    input  logic                clk,
    input  logic                res,
    input  logic [N_FLOORS-1:0] call_req,
    output logic [FLOOR_W-1:0]  cur_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                moving,
    output logic                dir_up,
    output logic                door_open
);

    localparam int TMR_MAX = (TRAVEL_CYC > DOOR_CYC) ? TRAVEL_CYC : DOOR_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;
    localparam logic [TMR_W-1:0]   TRAVEL_LD = TMR_W'(TRAVEL_CYC - 1);
    localparam logic [TMR_W-1:0]   DOOR_LD   = TMR_W'(DOOR_CYC - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(N_FLOORS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        DOOR = 2'd2
    } state_t;

    state_t             state;
    logic               last_up;
    logic [TMR_W-1:0]   travel_tmr;
    logic [TMR_W-1:0]   door_tmr;

    logic [FLOOR_W-1:0]  next_floor;
    logic [N_FLOORS-1:0] cur_oh;
    logic [N_FLOORS-1:0] next_oh;
    logic [N_FLOORS-1:0] above_cur;
    logic [N_FLOORS-1:0] below_cur;
    logic [N_FLOORS-1:0] above_next;
    logic [N_FLOORS-1:0] below_next;
    logic [N_FLOORS-1:0] clear_mask;
    logic                calls_above;
    logic                calls_below;
    logic                ahead_next;
    logic                pend_cur;
    logic                pend_next;
    logic                travel_done;
    logic                door_call;
    logic                go_up;

    // Floor masks and request qualifiers; above/below use thermometer masks so no index ever wraps
    always_comb begin
        next_floor = dir_up ? (cur_floor + FLOOR_W'(1)) : (cur_floor - FLOOR_W'(1));
        cur_oh     = '0;
        next_oh    = '0;
        above_cur  = '0;
        below_cur  = '0;
        above_next = '0;
        below_next = '0;
        for (int i = 0; i < N_FLOORS; i++) begin
            cur_oh[i]     = (FLOOR_W'(i) == cur_floor);
            next_oh[i]    = (FLOOR_W'(i) == next_floor);
            above_cur[i]  = (FLOOR_W'(i) >  cur_floor);
            below_cur[i]  = (FLOOR_W'(i) <  cur_floor);
            above_next[i] = (FLOOR_W'(i) >  next_floor);
            below_next[i] = (FLOOR_W'(i) <  next_floor);
        end
        calls_above = |(pending & above_cur);
        calls_below = |(pending & below_cur);
        ahead_next  = dir_up ? |(pending & above_next) : |(pending & below_next);
        pend_cur    = |(pending & cur_oh);
        pend_next   = |(pending & next_oh);
        travel_done = (travel_tmr == '0);
        door_call   = |(call_req & cur_oh);
        // with calls on both sides keep the previous heading, otherwise go where the calls are
        go_up       = (calls_above && calls_below) ? last_up : calls_above;
    end

    // Bits removed from pending this edge: the floor being served, and the open-door floor
    always_comb begin
        clear_mask = '0;
        if (door_open)
            clear_mask = clear_mask | cur_oh;
        if (state == IDLE && pend_cur)
            clear_mask = clear_mask | cur_oh;
        if (state == MOVE && travel_done && pend_next)
            clear_mask = clear_mask | next_oh;
    end

    // Controller state, timers, request latch and registered outputs
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state      <= IDLE;
            cur_floor  <= '0;
            pending    <= '0;
            moving     <= 1'b0;
            dir_up     <= 1'b1;
            door_open  <= 1'b0;
            travel_tmr <= '0;
            door_tmr   <= '0;
            last_up    <= 1'b1;
        end else begin
            pending <= (pending | call_req) & ~clear_mask;
            case (state)
                IDLE: begin
                    if (pend_cur) begin
                        state     <= DOOR;
                        door_open <= 1'b1;
                        door_tmr  <= DOOR_LD;
                    end else if (calls_above || calls_below) begin
                        state      <= MOVE;
                        moving     <= 1'b1;
                        dir_up     <= go_up;
                        last_up    <= go_up;
                        travel_tmr <= TRAVEL_LD;
                    end
                end
                MOVE: begin
                    if (!travel_done) begin
                        travel_tmr <= travel_tmr - TMR_W'(1);
                    end else begin
                        cur_floor <= next_floor;
                        // pin the heading at the end floors so it never points off the shaft
                        if (next_floor == TOP_FLOOR)
                            dir_up <= 1'b0;
                        else if (next_floor == '0)
                            dir_up <= 1'b1;
                        if (pend_next) begin
                            state     <= DOOR;
                            moving    <= 1'b0;
                            door_open <= 1'b1;
                            door_tmr  <= DOOR_LD;
                        end else if (ahead_next) begin
                            travel_tmr <= TRAVEL_LD;
                        end else begin
                            // only reachable if calls vanish mid-travel; stop rather than run on
                            state  <= IDLE;
                            moving <= 1'b0;
                        end
                    end
                end
                DOOR: begin
                    if (door_call) begin
                        door_tmr <= DOOR_LD;
                    end else if (door_tmr == '0) begin
                        state     <= IDLE;
                        door_open <= 1'b0;
                    end else begin
                        door_tmr <= door_tmr - TMR_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    moving    <= 1'b0;
                    door_open <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lift_scheduler.sv
// Purpose: self-checking bench for lift_scheduler with directed scenarios and random calls.
// Latency: outputs are checked #1 after every rising edge against a cycle-count reference model.
// Backpressure: not applicable; calls are driven on the falling edge.
module tb_lift_scheduler;

    localparam int NF = 4;
    localparam int FW = 2;
    localparam int TC = 8;
    localparam int DC = 5;

    localparam int M_IDLE   = 0;
    localparam int M_TRAVEL = 1;
    localparam int M_DOOR   = 2;

    logic          clk;
    logic          res;
    logic [NF-1:0] call_req;
    logic [FW-1:0] cur_floor;
    logic [NF-1:0] pending;
    logic          moving;
    logic          dir_up;
    logic          door_open;

    int total = 0;
    int bad   = 0;

    // reference model state: floor as an integer, elapsed-cycle counters instead of timers
    int            m_floor;
    logic [NF-1:0] m_pend;
    int            m_mode;
    int            m_trav;
    int            m_open;
    bit            m_moving;
    bit            m_dir;
    bit            m_door;
    bit            m_pref;

    lift_scheduler #(
        .N_FLOORS  (NF),
        .FLOOR_W   (FW),
        .TRAVEL_CYC(TC),
        .DOOR_CYC  (DC)
    ) dut (
        .clk      (clk),
        .res      (res),
        .call_req (call_req),
        .cur_floor(cur_floor),
        .pending  (pending),
        .moving   (moving),
        .dir_up   (dir_up),
        .door_open(door_open)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pbit(input logic [NF-1:0] p, input int i);
        logic [NF-1:0] t;
        t = p >> i;
        return t[0];
    endfunction

    function automatic bit any_call(input logic [NF-1:0] p, input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            if (i >= 0 && i < NF && pbit(p, i)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor  = 0;
        m_pend   = '0;
        m_mode   = M_IDLE;
        m_trav   = 0;
        m_open   = 0;
        m_moving = 1'b0;
        m_dir    = 1'b1;
        m_door   = 1'b0;
        m_pref   = 1'b1;
    endtask

    task automatic model_step(input logic [NF-1:0] req);
        int            served;
        int            f0;
        int            nf;
        bit            door0;
        bit            up;
        bit            dn;
        bit            ahead;
        logic [NF-1:0] p0;
        served = -1;
        f0     = m_floor;
        door0  = m_door;
        p0     = m_pend;
        case (m_mode)
            M_IDLE: begin
                if (pbit(p0, f0)) begin
                    served = f0;
                    m_mode = M_DOOR;
                    m_door = 1'b1;
                    m_open = 1;
                end else begin
                    up = any_call(p0, f0 + 1, NF - 1);
                    dn = any_call(p0, 0, f0 - 1);
                    if (up || dn) begin
                        m_dir    = (up && dn) ? m_pref : up;
                        m_pref   = m_dir;
                        m_moving = 1'b1;
                        m_mode   = M_TRAVEL;
                        m_trav   = 1;
                    end
                end
            end
            M_TRAVEL: begin
                if (m_trav < TC) begin
                    m_trav++;
                end else begin
                    nf      = m_dir ? f0 + 1 : f0 - 1;
                    ahead   = m_dir ? any_call(p0, nf + 1, NF - 1) : any_call(p0, 0, nf - 1);
                    m_floor = nf;
                    if (nf == NF - 1) m_dir = 1'b0;
                    if (nf == 0)      m_dir = 1'b1;
                    if (pbit(p0, nf)) begin
                        served   = nf;
                        m_mode   = M_DOOR;
                        m_moving = 1'b0;
                        m_door   = 1'b1;
                        m_open   = 1;
                    end else if (ahead) begin
                        m_trav = 1;
                    end else begin
                        m_mode   = M_IDLE;
                        m_moving = 1'b0;
                    end
                end
            end
            default: begin
                if (pbit(req, f0)) begin
                    m_open = 1;
                end else if (m_open == DC) begin
                    m_mode = M_IDLE;
                    m_door = 1'b0;
                end else begin
                    m_open++;
                end
            end
        endcase
        m_pend = p0 | req;
        if (served >= 0) m_pend = m_pend & ~(4'b0001 << served);
        if (door0)       m_pend = m_pend & ~(4'b0001 << f0);
    endtask

    // one clock: drive calls on the falling edge, step the model at the rising edge, compare after it
    task automatic tick(input logic [NF-1:0] req);
        @(negedge clk);
        call_req = req;
        @(posedge clk);
        model_step(req);
        #1;
        check("cur_floor", 32'(cur_floor), 32'(m_floor));
        check("pending",   32'(pending),   32'(m_pend));
        check("moving",    32'(moving),    32'(m_moving));
        check("door_open", 32'(door_open), 32'(m_door));
        if (m_moving) check("dir_up", 32'(dir_up), 32'(m_dir));
    endtask

    task automatic wait_idle(input int max);
        for (int i = 0; i < max; i++) begin
            if (moving === 1'b0 && door_open === 1'b0 && pending === 4'b0000) break;
            tick(4'b0000);
        end
        check("idle_wait", 32'({moving, door_open, pending}), 32'd0);
    endtask

    task automatic wait_door(input int max);
        for (int i = 0; i < max; i++) begin
            if (door_open === 1'b1) break;
            tick(4'b0000);
        end
        check("door_wait", 32'(door_open), 32'd1);
    endtask

    task automatic door_len(output int n);
        n = 1;
        for (int i = 0; i < 50; i++) begin
            tick(4'b0000);
            if (door_open !== 1'b1) break;
            n++;
        end
    endtask

    initial begin
        int  n;
        bit  mv;
        int  prev;
        int  seq[$];
        int  exp_seq[5];
        logic [NF-1:0] r;

        res      = 1'b1;
        call_req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_floor",   32'(cur_floor), 32'd0);
        check("rst_pending", 32'(pending),   32'd0);
        check("rst_moving",  32'(moving),    32'd0);
        check("rst_door",    32'(door_open), 32'd0);
        check("rst_dir",     32'(dir_up),    32'd1);
        @(negedge clk);
        res = 1'b0;

        // call to the current floor: door opens for exactly DC cycles, car never moves
        tick(4'b0001);
        check("s1_pend", 32'(pending), 32'h1);
        tick(4'b0000);
        check("s1_door_rise", 32'(door_open), 32'd1);
        mv = moving;
        n  = 1;
        for (int i = 0; i < 20; i++) begin
            tick(4'b0000);
            if (moving === 1'b1) mv = 1'b1;
            if (door_open !== 1'b1) break;
            n++;
        end
        check("s1_door_len", 32'(n), 32'(DC));
        check("s1_pend_clr", 32'(pending), 32'h0);
        check("s1_no_move", 32'(mv), 32'd0);

        // run to the top floor, one floor per TC cycles
        tick(4'b1000);
        tick(4'b0000);
        check("s2_moving", 32'(moving), 32'd1);
        check("s2_dir",    32'(dir_up), 32'd1);
        for (int k = 1; k <= 3; k++) begin
            repeat (TC) tick(4'b0000);
            check("s2_floor", 32'(cur_floor), 32'(k));
        end
        check("s2_door", 32'(door_open), 32'd1);
        check("s2_pend", 32'(pending), 32'h0);
        wait_idle(50);

        // back to floor 0, then pick up floor 2 on the way up to floor 3
        tick(4'b0001);
        tick(4'b0000);
        wait_idle(100);
        tick(4'b1000);
        tick(4'b0000);
        tick(4'b0000);
        tick(4'b0000);
        tick(4'b0100);
        wait_door(60);
        check("s3_stop2", 32'(cur_floor), 32'd2);
        door_len(n);
        check("s3_door_len", 32'(n), 32'(DC));
        wait_door(60);
        check("s3_stop3", 32'(cur_floor), 32'd3);
        wait_idle(50);

        // idle at floor 1 heading up with calls on both sides: up first, then down
        tick(4'b0001);
        tick(4'b0000);
        wait_idle(100);
        tick(4'b0010);
        tick(4'b0000);
        wait_idle(50);
        check("s4_start", 32'(cur_floor), 32'd1);
        tick(4'b1001);
        prev = int'(cur_floor);
        for (int i = 0; i < 200; i++) begin
            tick(4'b0000);
            if (int'(cur_floor) != prev) seq.push_back(int'(cur_floor));
            prev = int'(cur_floor);
            if (moving === 1'b0 && door_open === 1'b0 && pending === 4'b0000) break;
        end
        exp_seq = '{2, 3, 2, 1, 0};
        check("s4_seq_len", 32'(seq.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < seq.size()) check("s4_seq", 32'(seq[i]), 32'(exp_seq[i]));

        // repeat call to the open floor extends the door interval
        tick(4'b0100);
        tick(4'b0000);
        wait_door(60);
        check("s5_floor", 32'(cur_floor), 32'd2);
        n = 1;
        tick(4'b0000);
        if (door_open === 1'b1) n++;
        tick(4'b0000);
        if (door_open === 1'b1) n++;
        tick(4'b0100);
        if (door_open === 1'b1) n++;
        check("s5_no_latch", 32'(pending[2]), 32'd0);
        for (int i = 0; i < 50; i++) begin
            if (door_open !== 1'b1) break;
            tick(4'b0000);
            if (door_open === 1'b1) n++;
        end
        check("s5_door_len", 32'(n), 32'd8);
        wait_idle(50);

        // asynchronous reset between floors 1 and 2
        tick(4'b0001);
        tick(4'b0000);
        wait_idle(100);
        tick(4'b1000);
        tick(4'b0000);
        for (int i = 0; i < 40; i++) begin
            if (cur_floor === 2'd1) break;
            tick(4'b0000);
        end
        check("s6_at1", 32'(cur_floor), 32'd1);
        repeat (3) tick(4'b0000);
        check("s6_pend", 32'(pending), 32'h8);
        check("s6_moving", 32'(moving), 32'd1);
        #2;
        res = 1'b1;
        #1;
        check("s6_floor",   32'(cur_floor), 32'd0);
        check("s6_moving0", 32'(moving),    32'd0);
        check("s6_door",    32'(door_open), 32'd0);
        check("s6_pend0",   32'(pending),   32'h0);
        check("s6_dir",     32'(dir_up),    32'd1);
        call_req = '0;
        model_reset();
        @(negedge clk);
        res = 1'b0;

        // random calls against the reference model
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            tick(r);
        end
        wait_idle(400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
